// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port RAM access arbiter.
package mem_arb_pkg;

   localparam int ADDR_W          = 16;
   localparam int DATA_W          = 8;
   localparam int MEM_LATENCY_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_e;

endpackage

// File: rtl/mem_access_arbiter_arb2_rr.sv
// Two-request grant logic: a lone requester always wins; on a tie the pointer
// (or port 0 in fixed mode) decides. One-hot grant, purely combinational.
module arb2_rr (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   input  logic       fixed_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = req_i;
      if (&req_i) begin
         gnt_o = (fixed_i || !ptr_i) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one tick-driven single-port RAM between two requesters, one transaction
// at a time: IDLE (arbitrate/latch) -> ISSUE (tick) -> WAIT (latency) -> ACK.
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY    = MEM_LATENCY_DEF,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Req0,
   input  logic              We0,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [DATA_W-1:0] Wdata0,
   output logic              Ack0,
   input  logic              Req1,
   input  logic              We1,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [DATA_W-1:0] Wdata1,
   output logic              Ack1,
   output logic [DATA_W-1:0] Rdata,
   output logic              Busy,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_DataIn,
   output logic              Mem_WE,
   output logic              Mem_OE,
   output logic              Mem_Tick,
   input  logic [DATA_W-1:0] Mem_DataOut
);

   // Counter only ever holds MEM_LATENCY-1 down to 1.
   localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ptr_q, ptr_d;
   logic                gnt_q, gnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                we_q, we_d;
   logic                oe_q, oe_d;
   logic [1:0]          req;
   logic [1:0]          gnt_oh;

   assign req = {Req1, Req0};

   arb2_rr u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .fixed_i (FIXED_PRIORITY),
      .gnt_o   (gnt_oh)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|req) state_d = ST_ISSUE;
         ST_ISSUE: state_d = (MEM_LATENCY == 1) ? ST_ACK : ST_WAIT;
         ST_WAIT:  if (cnt_q == CNT_W'(1)) state_d = ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // RAM fields are captured only when leaving IDLE, so they stay stable through ACK.
   always_comb begin
      cnt_d  = cnt_q;
      ptr_d  = ptr_q;
      gnt_d  = gnt_q;
      addr_d = addr_q;
      din_d  = din_q;
      we_d   = we_q;
      oe_d   = oe_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d  = gnt_oh[1];
               addr_d = gnt_oh[1] ? Addr1  : Addr0;
               din_d  = gnt_oh[1] ? Wdata1 : Wdata0;
               we_d   = gnt_oh[1] ? We1    : We0;
               oe_d   = gnt_oh[1] ? !We1   : !We0;
            end
         end
         ST_ISSUE: cnt_d = CNT_LOAD;
         ST_WAIT:  cnt_d = cnt_q - CNT_W'(1);
         ST_ACK: begin
            if (!FIXED_PRIORITY) ptr_d = !gnt_q;
            we_d = 1'b0;
            oe_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q  <= '0;
         ptr_q  <= 1'b0;
         gnt_q  <= 1'b0;
         addr_q <= '0;
         din_q  <= '0;
         we_q   <= 1'b0;
         oe_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ptr_q  <= ptr_d;
         gnt_q  <= gnt_d;
         addr_q <= addr_d;
         din_q  <= din_d;
         we_q   <= we_d;
         oe_q   <= oe_d;
      end
   end

   assign Mem_Address = addr_q;
   assign Mem_DataIn  = din_q;
   assign Mem_WE      = we_q;
   assign Mem_OE      = oe_q;

   // The RAM output register keeps stale data across writes, so gate it to reads.
   always_comb begin
      Mem_Tick = (state_q == ST_ISSUE);
      Busy     = (state_q != ST_IDLE);
      Ack0     = (state_q == ST_ACK) && !gnt_q;
      Ack1     = (state_q == ST_ACK) &&  gnt_q;
      Rdata    = '0;
      if ((state_q == ST_ACK) && !we_q) Rdata = Mem_DataOut;
   end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-port, tick-driven 64K x 8 RAM between two requesters: port 0 is the CPU bus and port 1 is the loader/debug bus.
- Arbitrates each request, then drives the RAM's Address/DataIn/WE/OE fields with a one-cycle Tick strobe.
- Counts the fixed RAM pipeline latency and returns an acknowledge, plus read data, to the winning requester.
- Sits directly between the requesters and the RAM; it is the only driver of the RAM inputs.

Parameters:
- MEM_LATENCY, 3: cycles from the Tick cycle to the cycle in which Mem_DataOut holds the read result (minimum 1).
- FIXED_PRIORITY, 0: 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0  in  1  port 0 request; held high with stable fields until Ack0.
- We0  in  1  port 0 write (1) / read (0).
- Addr0  in  16  port 0 address.
- Wdata0  in  8  port 0 write data.
- Ack0  out  1  one-cycle completion pulse for port 0.
- Req1, We1, Addr1, Wdata1, Ack1: same as port 0, for port 1.
- Rdata  out  8  read data; valid only in a cycle where Ack0 or Ack1 is high and the granted request was a read.
- Busy  out  1  high whenever the state is not IDLE.
- Mem_Address  out  16  to RAM Address.
- Mem_DataIn  out  8  to RAM DataIn.
- Mem_WE  out  1  to RAM WE.
- Mem_OE  out  1  to RAM OE.
- Mem_Tick  out  1  to RAM Tick.
- Mem_DataOut  in  8  from RAM DataOut.

Behaviour:
- Reset values:
  - State IDLE; counter 0; round-robin pointer favours port 0.
  - Ack0, Ack1, Busy, Mem_Tick, Mem_WE and Mem_OE are 0.
  - Mem_Address and Mem_DataIn are 0; Rdata is 0 outside Ack cycles.
- States: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - If any Req is high, pick a winner. Only one requesting: it wins. Both requesting: the port the pointer favours wins when FIXED_PRIORITY=0; port 0 wins when FIXED_PRIORITY=1.
  - Register the winner's Addr into Mem_Address and Wdata into Mem_DataIn; set Mem_WE = We; set Mem_OE = ~We.
  - Register the grant index, then go to ISSUE.
- ISSUE:
  - Mem_Tick = 1 for exactly this cycle; the RAM samples its fields at the end of this cycle.
  - Load the counter with MEM_LATENCY-1. If MEM_LATENCY=1 go straight to ACK, otherwise go to WAIT.
- WAIT:
  - Mem_Tick = 0; decrement the counter.
  - When the counter reaches 1 (i.e. after MEM_LATENCY-1 WAIT cycles), go to ACK.
- ACK:
  - Assert the granted port's Ack for one cycle.
  - Rdata = Mem_DataOut combinationally for a read; 0 for a write. The RAM output register holds its old value on writes, so Rdata must not pass it through.
  - In round-robin mode, point the pointer at the other port. Go to IDLE.
- RAM field stability: Mem_Address, Mem_DataIn, Mem_WE and Mem_OE hold from ISSUE through ACK and change only in IDLE.
- Timing:
  - Request accepted in cycle N gives Tick in N+1 and Ack in N+1+MEM_LATENCY.
  - A back-to-back transaction costs MEM_LATENCY+2 cycles.
- Req held high in the Ack cycle is a new request and is arbitrated in the following IDLE.
- A requester that drops Req before its Ack still gets its transaction completed and acknowledged; no cancellation.
- Simultaneous requests in round-robin mode alternate 0,1,0,1 while both are held.
- Reset mid-operation:
  - Return to IDLE and clear all outputs next cycle.
  - A Tick already sampled by the RAM still completes inside the RAM, so a write may land; no Ack is issued for it.
- There is never more than one outstanding RAM transaction.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE, ISSUE, WAIT, ACK).
  - ADDR_W=16, DATA_W=8.
  - Default MEM_LATENCY.
- Sub-module arb2_rr: 2-request grant logic.
  - Inputs: req[1:0], pointer, fixed-mode flag.
  - Output: one-hot grant.
  - Purely combinational. The pointer register stays in the parent.

Test Plan:
- Single read: Req0 with Addr0=0x0037, We0=0, cycle N -> Mem_Tick in N+1 only; Ack0 in N+4 with Rdata=0xDD; Busy high N+1..N+4.
- Write then read:
  - Port 1 writes 0x5A to 0x0200 -> Ack1, Rdata=0.
  - Port 1 then reads 0x0200 -> Ack1 with Rdata=0x5A.
  - Mem_WE=1 only during the write transaction.
- Contention, round-robin: Req0 (read 0x0107) and Req1 (read 0x0110) held simultaneously -> acks alternate 0,1,0,1 with Rdata 0xAA, 0xBB. With FIXED_PRIORITY=1 -> only Ack0 while Req0 is held.
- Early drop: Req0 deasserted the cycle after acceptance -> Ack0 still pulses at N+4 and no second Tick is issued.
- Reset mid-WAIT: Reset in N+2 of a read -> outputs 0 and state IDLE at N+3; no Ack; next request proceeds normally.
- Boundary: read 0xFFFF and write/read 0x0000 with value 0xFF -> correct address on Mem_Address, no wrap artefacts; MEM_LATENCY=1 build gives Ack at N+2.
